// File: rtl/vote_ballot_collector.sv
// Ballot collector for the 4-voter tally: opens a session, gathers one vote per voter,
// and presents the ballot under valid/ready. Optional session timeout: VOTE_TIMEOUT_EN.
module vote_ballot_collector #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       OPEN,
   input  logic [3:0] V,
   input  logic [3:0] S,
   output logic [3:0] I,
   output logic       BV,
   input  logic       BR,
   output logic [3:0] CAST,
   output logic       BUSY,
   output logic       ERR,
   output logic       TMO
);

   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_PRESENT} state_e;

   state_e     state_q, state_d;
   logic [3:0] ballot_q, ballot_d;
   logic [3:0] cast_q, cast_d;
   logic       err_q, err_d;
   logic       tmo_q, tmo_d;
   logic       tmo_hit;

`ifdef VOTE_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE && OPEN) cnt_d = '0;
      else if (state_q == ST_COLLECT) cnt_d = cnt_q + 1'b1;
   end

   assign tmo_hit = (state_q == ST_COLLECT) && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ballot_d = ballot_q;
      cast_d   = cast_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (OPEN) begin
               state_d  = ST_COLLECT;
               ballot_d = '0;
               cast_d   = '0;
               err_d    = 1'b0;
               tmo_d    = 1'b0;
            end
         end
         ST_COLLECT: begin
            // First vote wins; a repeat submit only raises the sticky error.
            for (int k = 0; k < 4; k++) begin
               if (S[k]) begin
                  if (!cast_q[k]) begin
                     ballot_d[k] = V[k];
                     cast_d[k]   = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            if (cast_d == 4'b1111) begin
               state_d = ST_PRESENT;
            end else if (tmo_hit) begin
               state_d = ST_PRESENT;
               tmo_d   = 1'b1;
            end
         end
         ST_PRESENT: begin
            if (BR) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ballot_q <= '0;
         cast_q   <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ballot_q <= ballot_d;
         cast_q   <= cast_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign I    = ballot_q;
   assign BV   = (state_q == ST_PRESENT);
   assign BUSY = (state_q != ST_IDLE);
   assign CAST = cast_q;
   assign ERR  = err_q;
   assign TMO  = tmo_q;

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for vote_ballot_collector; the timeout scenario adapts to VOTE_TIMEOUT_EN.
module tb_vote_ballot_collector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       OPEN = 1'b0;
   logic [3:0] V = '0;
   logic [3:0] S = '0;
   logic [3:0] I;
   logic       BV;
   logic       BR = 1'b0;
   logic [3:0] CAST;
   logic       BUSY;
   logic       ERR;
   logic       TMO;

   int vectors = 0;
   int miscompares = 0;

   vote_ballot_collector #(.TIMEOUT(10), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .OPEN(OPEN), .V(V), .S(S), .I(I), .BV(BV),
      .BR(BR), .CAST(CAST), .BUSY(BUSY), .ERR(ERR), .TMO(TMO)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] ei, input logic ebv,
                          input logic [3:0] ecast, input logic ebusy, input logic eerr,
                          input logic etmo);
      chk({tag, ".I"}, I, ei);
      chk({tag, ".BV"}, {3'b0, BV}, {3'b0, ebv});
      chk({tag, ".CAST"}, CAST, ecast);
      chk({tag, ".BUSY"}, {3'b0, BUSY}, {3'b0, ebusy});
      chk({tag, ".ERR"}, {3'b0, ERR}, {3'b0, eerr});
      chk({tag, ".TMO"}, {3'b0, TMO}, {3'b0, etmo});
   endtask

   initial begin
      // reset state
      #3;
      chk_all("rst", 4'b0000, 0, 4'b0000, 0, 0, 0);
      #4 rst_n = 1'b1;
      // S ignored in IDLE
      S = 4'b1111; V = 4'b1111;
      tick();
      S = '0; V = '0;
      chk_all("idle_s", 4'b0000, 0, 4'b0000, 0, 0, 0);

      // sequential votes, BR held high
      OPEN = 1; tick(); OPEN = 0;
      chk_all("t1_open", 4'b0000, 0, 4'b0000, 1, 0, 0);
      S = 4'b0001; V = 4'b0001; tick();
      chk("t1_c0", CAST, 4'b0001);
      S = 4'b0010; V = 4'b0000; tick();
      S = 4'b0100; V = 4'b0100; tick();
      chk("t1_c2", CAST, 4'b0111);
      S = 4'b1000; V = 4'b0000; BR = 1; tick();
      S = '0;
      chk_all("t1_bv", 4'b0101, 1, 4'b1111, 1, 0, 0);
      tick();
      chk_all("t1_done", 4'b0101, 0, 4'b1111, 0, 0, 0);
      BR = 0;

      // all four at once, consumer stalls 5 cycles
      OPEN = 1; tick(); OPEN = 0;
      S = 4'b1111; V = 4'b1011; tick(); S = '0; V = '0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_bv_stall", {3'b0, BV}, 4'b0001);
         chk("t2_i_stall", I, 4'b1011);
         tick();
      end
      BR = 1;
      chk("t2_bv6", {3'b0, BV}, 4'b0001);
      chk("t2_i6", I, 4'b1011);
      tick();
      chk("t2_bv_off", {3'b0, BV}, 4'b0000);
      tick();
      chk("t2_busy_off", {3'b0, BUSY}, 4'b0000);
      chk("t2_bv_once", {3'b0, BV}, 4'b0000);
      BR = 0;

      // duplicate vote: first wins, ERR sticky
      OPEN = 1; tick(); OPEN = 0;
      S = 4'b0001; V = 4'b0001; tick();
      S = 4'b0001; V = 4'b0000; tick();
      chk_all("t3_dup", 4'b0001, 0, 4'b0001, 1, 1, 0);
      S = 4'b1110; V = 4'b0000; tick(); S = '0;
      chk_all("t3_bv", 4'b0001, 1, 4'b1111, 1, 1, 0);
      BR = 1; tick(); BR = 0;
      OPEN = 1; tick(); OPEN = 0;
      chk_all("t3_reopen", 4'b0000, 0, 4'b0000, 1, 0, 0);

      // OPEN ignored mid-session, S ignored in PRESENT
      S = 4'b0011; V = 4'b0011; tick(); S = '0;
      chk("t4_c2", CAST, 4'b0011);
      OPEN = 1; tick(); OPEN = 0;
      chk_all("t4_open_ign", 4'b0011, 0, 4'b0011, 1, 0, 0);
      S = 4'b1100; V = 4'b1000; tick();
      chk_all("t4_bv", 4'b1011, 1, 4'b1111, 1, 0, 0);
      S = 4'b1111; V = 4'b0000; tick(); S = '0;
      chk_all("t4_s_ign", 4'b1011, 1, 4'b1111, 1, 0, 0);
      BR = 1; tick(); BR = 0;
      chk("t4_bv_off", {3'b0, BV}, 4'b0000);

      // async reset mid-COLLECT
      OPEN = 1; tick(); OPEN = 0;
      S = 4'b0011; V = 4'b0001; tick(); S = '0; V = '0;
      chk("t5_c2", CAST, 4'b0011);
      #1 rst_n = 1'b0;
      #1 chk_all("t5_rst", 4'b0000, 0, 4'b0000, 0, 0, 0);
      rst_n = 1'b1;
      OPEN = 1; tick(); OPEN = 0;
      chk_all("t5_clean", 4'b0000, 0, 4'b0000, 1, 0, 0);
      S = 4'b1111; V = 4'b0110; tick(); S = '0;
      chk_all("t5_bv", 4'b0110, 1, 4'b1111, 1, 0, 0);
      BR = 1; tick(); BR = 0;
      chk("t5_busy_off", {3'b0, BUSY}, 4'b0000);

      // single vote, then wait out the session length (TIMEOUT=10)
      OPEN = 1; tick(); OPEN = 0;
      S = 4'b0100; V = 4'b0100; tick(); S = '0; V = '0;
      for (int i = 0; i < 8; i++) tick();
      chk("t6_pre_bv", {3'b0, BV}, 4'b0000);
      tick();
`ifdef VOTE_TIMEOUT_EN
      chk_all("t6_tmo", 4'b0100, 1, 4'b0100, 1, 0, 1);
      BR = 1; tick(); BR = 0;
      chk("t6_done", {3'b0, BUSY}, 4'b0000);
`else
      chk_all("t6_wait", 4'b0100, 0, 4'b0100, 1, 0, 0);
      tick();
      chk("t6_still", {3'b0, BUSY}, 4'b0001);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
